mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 128 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Brief    : Four requesters share one M x M signed multiplier. A round-robin
//            arbiter feeds a two-stage pipeline: S1 holds the operands and the
//            tag, and S2 holds the full 2M-bit product and the tag. Downstream
//            backpressure stalls both stages.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
    parameter int BF_MULT_BITS = 16
) (
    input  logic                        xClk,
    input  logic                        xRst_n,
    input  logic [3:0]                  xReqValid,
    input  logic [4*BF_MULT_BITS-1:0]   xReqA,
    input  logic [4*BF_MULT_BITS-1:0]   xReqB,
    output logic [3:0]                  xReqReady,
    output logic                        xResValid,
    input  logic                        xResReady,
    output logic [2*BF_MULT_BITS-1:0]   xResProduct,
    output logic [1:0]                  xResTag,
    output logic                        xBusy
);

    localparam int NREQ = 4;
    localparam int M    = BF_MULT_BITS;

    // Round-robin pointer and pipeline state
    logic [1:0]     r_ptr;
    logic           r_s1_valid;
    logic [M-1:0]   r_s1_a;
    logic [M-1:0]   r_s1_b;
    logic [1:0]     r_s1_tag;
    logic           r_s2_valid;
    logic [2*M-1:0] r_s2_prod;
    logic [1:0]     r_s2_tag;

    logic           w_adv;
    logic [3:0]     w_grant;
    logic [1:0]     w_grant_idx;
    logic           w_found;
    logic [1:0]     w_scan;
    logic           w_accept;
    logic [2*M-1:0] w_a_ext;
    logic [2*M-1:0] w_b_ext;
    logic [2*M-1:0] w_prod;

    // The pipeline moves unless S2 holds a result that nobody is taking.
    assign w_adv = !(r_s2_valid && !xResReady);

    // First valid requester at or above the pointer, wrapping modulo 4;
    // no grant while stalled or while reset is held.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = r_ptr + k[1:0];
            if (!w_found && xReqValid[w_scan]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan;
            end
        end
        if (w_found && w_adv && xRst_n) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_accept  = |w_grant;
    assign xReqReady = w_grant;

    // Sign-extend both operands to 2M bits; the low 2M bits of the unsigned
    // product of the extended values are then the exact signed product.
    assign w_a_ext = {{M{r_s1_a[M-1]}}, r_s1_a};
    assign w_b_ext = {{M{r_s1_b[M-1]}}, r_s1_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Pointer moves to the slot after the requester just served.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            r_ptr <= 2'd0;
        end else if (w_accept) begin
            r_ptr <= w_grant_idx + 2'd1;
        end
    end

    // S1: capture the granted operands, or a bubble when nothing is accepted.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a   <= xReqA[w_grant_idx*M +: M];
                r_s1_b   <= xReqB[w_grant_idx*M +: M];
                r_s1_tag <= w_grant_idx;
            end
        end
    end

    // S2: register the product; the data is held across bubbles so that the
    // outputs change only when a new result arrives.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_tag   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod <= w_prod;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign xResValid   = r_s2_valid;
    assign xResProduct = r_s2_prod;
    assign xResTag     = r_s2_tag;
    assign xBusy       = r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Brief    : Self-checking bench for mult_share_arbiter. A transaction-level
//            model (ordered queue of accepted operations plus a pointer)
//            predicts grants, result timing, tags and products.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int M = 16;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req_valid;
    logic [4*M-1:0] req_a;
    logic [4*M-1:0] req_b;
    logic [3:0]     req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [2*M-1:0] res_product;
    logic [1:0]     res_tag;
    logic           busy;

    mult_share_arbiter #(.BF_MULT_BITS(M)) dut (
        .xClk        (clk),
        .xRst_n      (rst_n),
        .xReqValid   (req_valid),
        .xReqA       (req_a),
        .xReqB       (req_b),
        .xReqReady   (req_ready),
        .xResValid   (res_valid),
        .xResReady   (res_ready),
        .xResProduct (res_product),
        .xResTag     (res_tag),
        .xBusy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [1:0]     tag;
        logic [2*M-1:0] prod;
        int             cyc;
    } op_t;

    op_t q[$];
    int  ptr;
    int  now;
    int  checks;
    int  failures;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    function automatic logic [2*M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p[2*M-1:0];
    endfunction

    task automatic set_op(input int i, input logic [M-1:0] a, input logic [M-1:0] b);
        req_a[i*M +: M] = a;
        req_b[i*M +: M] = b;
    endtask

    // One clock cycle: inputs are already driven; compare at the falling
    // edge, advance the model, then return just after the rising edge.
    task automatic step();
        bit         exp_rv;
        bit         adv;
        logic [3:0] exp_grant;
        int         gidx;
        int         idx;
        op_t        op;
        @(negedge clk);
        exp_rv = (q.size() > 0) && (q[0].cyc + 2 <= now);
        check_eq("res_valid", 64'(res_valid), 64'(exp_rv));
        check_eq("busy", 64'(busy), 64'(q.size() > 0));
        if (exp_rv) begin
            check_eq("res_tag", 64'(res_tag), 64'(q[0].tag));
            check_eq("res_product", 64'(res_product), 64'(q[0].prod));
        end
        adv       = !(exp_rv && !res_ready);
        exp_grant = '0;
        gidx      = -1;
        if (adv) begin
            for (int k = 0; k < 4; k++) begin
                idx = (ptr + k) % 4;
                if (gidx < 0 && req_valid[idx]) gidx = idx;
            end
        end
        if (gidx >= 0) exp_grant[gidx] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_grant));
        if (exp_rv && res_ready) void'(q.pop_front());
        if (gidx >= 0) begin
            op.tag  = gidx[1:0];
            op.prod = ref_mul(req_a[gidx*M +: M], req_b[gidx*M +: M]);
            op.cyc  = now;
            q.push_back(op);
            ptr = (gidx + 1) % 4;
        end
        now++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},   64'(req_ready),   64'(0));
        check_eq({tag, "_valid"},   64'(res_valid),   64'(0));
        check_eq({tag, "_busy"},    64'(busy),        64'(0));
        check_eq({tag, "_product"}, 64'(res_product), 64'(0));
        check_eq({tag, "_tag"},     64'(res_tag),     64'(0));
    endtask

    function automatic logic [M-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        ptr       = 0;
        now       = 0;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // Reset state, with every requester asking
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'h0;

        // Single operation from requester 2: 3 x -2
        set_op(2, 16'h0003, 16'hFFFE);
        req_valid = 4'b0100;
        step();
        req_valid = 4'h0;
        repeat (3) step();

        // Round robin with all requesters active
        for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'(10 * (i + 1)));
        req_valid = 4'hF;
        repeat (8) step();

        // Backpressure for 5 cycles while results are pending
        res_ready = 1'b0;
        repeat (5) step();
        res_ready = 1'b1;
        repeat (4) step();
        req_valid = 4'h0;
        repeat (3) step();

        // Arithmetic corners through requester 0
        req_valid = 4'b0001;
        set_op(0, 16'h8000, 16'h8000); step();
        set_op(0, 16'h8000, 16'h0001); step();
        set_op(0, 16'h7FFF, 16'h7FFF); step();
        req_valid = 4'h0;
        repeat (3) step();

        // Wrap and fairness: move pointer to 3, then only 0 and 3 request
        set_op(2, 16'h0005, 16'h0007);
        req_valid = 4'b0100;
        step();
        set_op(0, 16'h1111, 16'h0002);
        set_op(3, 16'h0033, 16'hFFFF);
        req_valid = 4'b1001;
        repeat (3) step();
        req_valid = 4'h0;
        repeat (3) step();

        // Reset while two operations are in flight
        set_op(1, 16'h0100, 16'h0100);
        req_valid = 4'b0010;
        repeat (2) step();
        req_valid = 4'hF;
        rst_n     = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        ptr = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'h0;
        repeat (4) step();

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) set_op(i, rand_operand(), rand_operand());
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 4'h0;
        res_ready = 1'b1;
        repeat (4) step();
        check_eq("drain_empty", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
